// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction-fetch sequencer with PC, 2-entry fetch buffer and redirect handling
module fetch_controller #(
    parameter int                          INSTRUCTION_SIZE = 32,
    parameter logic [INSTRUCTION_SIZE-1:0] RESET_PC         = '0,
    parameter int                          BUF_DEPTH        = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        Start,
    input  logic                        Stop,
    input  logic                        Redirect,
    input  logic [INSTRUCTION_SIZE-1:0] RedirectPC,
    output logic [INSTRUCTION_SIZE-1:0] InstructionAddress,
    input  logic [INSTRUCTION_SIZE-1:0] ReadInstruction,
    output logic                        FetchValid,
    input  logic                        FetchReady,
    output logic [INSTRUCTION_SIZE-1:0] FetchInstruction,
    output logic [INSTRUCTION_SIZE-1:0] FetchPC,
    output logic                        FetchError,
    output logic [31:0]                 IssuedCount
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, ERROR} state_t;

    state_t                      state;
    logic [INSTRUCTION_SIZE-1:0] pc;
    logic [INSTRUCTION_SIZE-1:0] fb_instr [BUF_DEPTH];
    logic [INSTRUCTION_SIZE-1:0] fb_pc    [BUF_DEPTH];
    logic [PTR_W-1:0]            head;
    logic [PTR_W-1:0]            tail;
    logic [CNT_W-1:0]            count;
    logic                        aligned;
    logic                        live_redirect;
    logic                        full;
    logic                        pop;
    logic                        push;

    // Redirect is ignored once trapped; a misaligned target traps instead of loading
    assign aligned       = (RedirectPC[1:0] == 2'b00);
    assign live_redirect = Redirect && (state != ERROR);
    assign full          = (count == FULL_COUNT);

    // Head is hidden during a redirect cycle so a doomed entry is never handed to decode
    assign FetchValid       = (count != '0) && !Redirect && (state != ERROR);
    assign FetchInstruction = fb_instr[head];
    assign FetchPC          = fb_pc[head];
    assign InstructionAddress = pc;

    assign pop  = FetchValid && FetchReady;
    assign push = (state == RUN) && !Stop && !Redirect && (!full || pop);

    // Control FSM: state, PC and the sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            FetchError <= 1'b0;
        end else if (state != ERROR) begin
            if (Redirect && !aligned) begin
                state      <= ERROR;
                FetchError <= 1'b1;
            end else begin
                if (Redirect) begin
                    pc <= RedirectPC;
                end else if (push) begin
                    pc <= pc + INSTRUCTION_SIZE'(4);
                end
                if (state == RUN && Stop) begin
                    state <= IDLE;
                end else if (state == IDLE && Start) begin
                    state <= RUN;
                end
            end
        end
    end

    // Circular fetch buffer and handshake counter; any live redirect flushes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                fb_instr[i] <= '0;
                fb_pc[i]    <= '0;
            end
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            IssuedCount <= '0;
        end else if (live_redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                fb_instr[tail] <= ReadInstruction;
                fb_pc[tail]    <= pc;
                tail           <= tail + PTR_W'(1);
            end
            if (pop) begin
                head        <= head + PTR_W'(1);
                IssuedCount <= IssuedCount + 32'd1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer sitting between the program counter logic and the combinational `InstructionMemory`. Owns the PC, drives `InstructionAddress`, captures `ReadInstruction` into a 2-entry fetch buffer, and presents instructions to decode over a valid/ready handshake. Handles start/stop, branch/jump redirects with buffer flush, and misaligned-target error trapping.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `INSTRUCTION_SIZE`, 32, instruction and address width.
- `BUF_DEPTH`, 2, fetch buffer entries; power of two, ≥2.

- `clk`  in  1  rising-edge clock; single clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `Start`  in  1  pulse; IDLE→RUN.
- `Stop`  in  1  pulse; RUN→IDLE, buffered entries still drain.
- `Redirect`  in  1  load new PC and flush buffer.
- `RedirectPC`  in  32  redirect target.
- `InstructionAddress`  out  32  address to InstructionMemory; equals PC register.
- `ReadInstruction`  in  32  combinational instruction from memory for `InstructionAddress`.
- `FetchValid`  out  1  buffer head valid.
- `FetchReady`  in  1  decode accepts head.
- `FetchInstruction`  out  32  head instruction.
- `FetchPC`  out  32  head PC.
- `FetchError`  out  1  sticky misaligned-redirect flag.
- `IssuedCount`  out  32  number of completed handshakes.

## Operation
- States: IDLE, RUN, ERROR. Reset → IDLE.
- IDLE: no pushes. `Start`=1 → RUN. `Stop` ignored.
- RUN: `Stop`=1 → IDLE (no push that cycle). `Start` ignored.
- ERROR: entered on misaligned redirect in any state; exit only by reset. No pushes, buffer empty, `FetchValid`=0.
- Push (RUN only): when not full or a pop occurs same cycle, write {PC, `ReadInstruction`} at tail, PC ← PC+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Pop: `FetchValid` && `FetchReady`; head advances, `IssuedCount` += 1 (wraps).
- Simultaneous push and pop when full: both occur, count unchanged; full-rate throughput is 1 instruction/cycle.
- Redirect (highest priority, any state except ERROR):
  - `RedirectPC[1:0]`==0: buffer flushed (count←0), PC ← `RedirectPC`, no push, state unchanged (IDLE stays IDLE).
  - `RedirectPC[1:0]`!=0: buffer flushed, PC unchanged, state → ERROR, `FetchError` ← 1.
  - `FetchValid` forced 0 during the cycle `Redirect`=1; no pop, no count increment.
- `Redirect` with `Start` or `Stop` same cycle: redirect applies and state transition also applies (unless misaligned → ERROR wins).
- Buffer: circular, head/tail pointers wrap at `BUF_DEPTH`; count 0..`BUF_DEPTH`.

## Timing
- Reset values: PC=`RESET_PC`, `InstructionAddress`=`RESET_PC`, `FetchValid`=0, `FetchInstruction`=0, `FetchPC`=0, `FetchError`=0, `IssuedCount`=0, state IDLE, buffer empty.
- `InstructionAddress` is the registered PC; memory data is consumed the same cycle.
- Start latency: `Start` in cycle N → RUN at N+1, first push at end of N+1, `FetchValid`=1 in N+2 with `FetchPC`=PC.
- Redirect latency: `Redirect` in N → `InstructionAddress`=`RedirectPC` in N+1 → `FetchValid` with `FetchPC`=`RedirectPC` in N+2.
- Stop: `Stop` in N → no push at end of N; entries present drain at one per accepted handshake.
- `FetchValid`/`FetchInstruction`/`FetchPC` are registered (from buffer), stable while `FetchValid`=1 and `FetchReady`=0.
- Reset asserted mid-operation: all state returns to reset values asynchronously; in-flight entries lost.

## Test plan
- Reset, `Start` pulse, `FetchReady`=1 held, memory per program (0:00000033, 4:00100093, 8:00200113, 12:00300193) → from N+2, one handshake/cycle, `FetchPC`=0,4,8,12 with matching instructions; `IssuedCount`=4 after four.
- `FetchReady`=0 for 5 cycles after Start → buffer fills to 2 (`FetchPC`=0 held, `InstructionAddress`=8 stalled); release → 0,4,8 delivered back-to-back, no loss/duplication.
- Redirect to 32'h0000_0040 while buffer full → `FetchValid`=0 in redirect cycle, old entries discarded, next delivered `FetchPC`=0x40 two cycles later, `IssuedCount` unaffected by discarded entries.
- Redirect to 32'h0000_0042 → `FetchError`=1 next cycle, `FetchValid`=0 permanently, `Start` ignored; `rst_n` pulse clears to reset values.
- `Stop` with 2 entries buffered → both drain, then `FetchValid`=0; `Start` resumes from next sequential PC (e.g. 8).
- Redirect to 32'hFFFF_FFFC then run → `FetchPC` sequence FFFFFFFC, 00000000, 00000004 (wrap).
